// File: rtl/core_pkg.sv
// Shared front-end types and constants for the fetch path.
package core_pkg;

  localparam int unsigned PC_W     = 16;
  localparam int unsigned INSTR_W  = 16;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch unit bus bundle: branch resolution, instruction-memory port and decode port.
interface fetch_redirect_unit_if;
  import core_pkg::*;

  logic [PC_W-1:0]    branchpc;
  logic               isbranchtaken;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [PC_W-1:0]    dec_pc;

  modport master (
    input  branchpc, isbranchtaken, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output branchpc, isbranchtaken, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and a registered head.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  fetch_entry_t                   din,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && !flush && (count != '0);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Head register tracks the entry that will sit at rd_ptr after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (do_pop) begin
        if (count > CW'(1))  head <= mem[rd_ptr + AW'(1)];
        else if (do_push)    head <= din;
      end else if (do_push && (count == '0)) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: credit-limited in-order imem requests, response buffering and branch redirect.
module fetch_redirect_unit
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  fetch_redirect_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] resp_pc;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   squash_cnt;
  logic [CW-1:0]   count;
  logic            req_fire;
  logic            resp_keep;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Requests are only issued while queue slots cover every outstanding beat.
  always_comb begin
    bus.imem_req_valid = rst_n && !bus.isbranchtaken &&
                         ((SW'(in_flight) + SW'(count)) < SW'(DEPTH));
    bus.imem_req_addr  = fetch_pc;
    bus.dec_valid      = (count != '0) && !bus.isbranchtaken;
    bus.dec_instr      = head.instr;
    bus.dec_pc         = head.pc;
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    resp_keep          = bus.imem_resp_valid && (squash_cnt == '0) && !bus.isbranchtaken;
    pop                = bus.dec_valid && bus.dec_ready;
    push_entry.pc      = resp_pc;
    push_entry.instr   = bus.imem_resp_data;
  end

  // Redirect reloads both PCs and marks every still-pending beat as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      in_flight  <= '0;
      squash_cnt <= '0;
    end else begin
      in_flight <= in_flight + CW'(req_fire) - CW'(bus.imem_resp_valid);
      if (bus.isbranchtaken) begin
        fetch_pc   <= bus.branchpc;
        resp_pc    <= bus.branchpc;
        squash_cnt <= in_flight - CW'(bus.imem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_W'(1);
        if (bus.imem_resp_valid) begin
          if (squash_cnt != '0) squash_cnt <= squash_cnt - CW'(1);
          else                  resp_pc    <= resp_pc + PC_W'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.isbranchtaken),
    .push  (resp_keep),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomised bench for fetch_redirect_unit against a request/response queue model.
module tb_fetch_redirect_unit;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
    bit              stale;
  } mreq_t;

  logic clk;
  logic rst_n;

  fetch_redirect_unit_if bus();

  fetch_redirect_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int              total;
  int              bad;
  int              cyc;
  int              lat_lo;
  int              lat_hi;
  logic [PC_W-1:0] fpc;
  mreq_t           mem_q[$];
  fetch_entry_t    mq[$];
  logic [PC_W-1:0] seen[$];
  logic [PC_W-1:0] acc_addr[$];
  int              pop_cyc[$];
  int              acc_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic clear_logs();
    seen.delete();
    acc_addr.delete();
    pop_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic idle_inputs();
    bus.isbranchtaken   = 1'b0;
    bus.branchpc        = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.dec_ready       = 1'b0;
  endtask

  task automatic model_reset();
    mem_q.delete();
    mq.delete();
    fpc = RESET_PC;
    clear_logs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive, check against the model, then advance the model at the edge.
  task automatic cycle(input logic br, input logic [PC_W-1:0] bpc, input logic dr, input logic rr);
    logic         rv, e_rv, e_dv, acc, pop;
    mreq_t        r;
    fetch_entry_t e;
    @(negedge clk);
    rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    bus.isbranchtaken   = br;
    bus.branchpc        = bpc;
    bus.dec_ready       = dr;
    bus.imem_req_ready  = rr;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rv ? instr_of(mem_q[0].addr) : INSTR_W'($urandom);
    #2;
    e_rv = !br && ((mem_q.size() + mq.size()) < DEPTH);
    e_dv = !br && (mq.size() != 0);
    total++;
    if (bus.imem_req_valid !== e_rv) begin
      bad++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, e_rv);
    end
    if (e_rv) begin
      total++;
      if (bus.imem_req_addr !== fpc) begin
        bad++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, fpc);
      end
    end
    total++;
    if (bus.dec_valid !== e_dv) begin
      bad++;
      $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, bus.dec_valid, e_dv);
    end
    if (e_dv) begin
      total++;
      if (bus.dec_pc !== mq[0].pc || bus.dec_instr !== mq[0].instr) begin
        bad++;
        $display("FAIL dec_head cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.dec_pc, bus.dec_instr,
                 mq[0].pc, mq[0].instr);
      end
    end
    acc = e_rv && rr;
    pop = e_dv && dr;
    if (pop) begin seen.push_back(bus.dec_pc); pop_cyc.push_back(cyc); end
    if (acc) begin acc_addr.push_back(fpc); acc_cyc.push_back(cyc); end
    @(posedge clk);
    if (rv) begin
      r = mem_q.pop_front();
      if (!br && !r.stale) begin
        e.pc    = r.addr;
        e.instr = instr_of(r.addr);
        mq.push_back(e);
      end
    end
    if (br) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      mq.delete();
      fpc = bpc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        r.addr  = fpc;
        r.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
        r.stale = 1'b0;
        mem_q.push_back(r);
        fpc = fpc + 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_seen(input string name, input int idx, input logic [PC_W-1:0] exp);
    total++;
    if (seen.size() <= idx || seen[idx] !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h exp=%h (popped=%0d)", name, idx,
               (seen.size() > idx) ? seen[idx] : 16'hxxxx, exp, seen.size());
    end
  endtask

  task automatic test_reset();
    #2;
    total += 4;
    if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", bus.imem_req_valid); end
    if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid got=%b exp=0", bus.dec_valid); end
    if (bus.dec_pc !== '0) begin bad++; $display("FAIL rst_dec_pc got=%h exp=0", bus.dec_pc); end
    if (bus.dec_instr !== '0) begin bad++; $display("FAIL rst_dec_instr got=%h exp=0", bus.dec_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total += 2;
    if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL rel_req_valid got=%b exp=1", bus.imem_req_valid); end
    if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rel_dec_valid got=%b exp=0", bus.dec_valid); end
  endtask

  task automatic test_stream();
    lat_lo = 1; lat_hi = 1;
    repeat (12) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (acc_addr.size() <= i || acc_addr[i] !== PC_W'(i)) begin
        bad++;
        $display("FAIL stream_req idx=%0d exp=%0d (accepted=%0d)", i, i, acc_addr.size());
      end
    end
    for (int i = 0; i < 6; i++) check_seen("stream_pop", i, PC_W'(i));
    total += 2;
    if (pop_cyc.size() < 6 || acc_cyc.size() < 1 || pop_cyc[0] != acc_cyc[0] + 2) begin
      bad++;
      $display("FAIL stream_first_latency got=%0d exp=%0d", pop_cyc.size() > 0 ? pop_cyc[0] : -1,
               acc_cyc.size() > 0 ? acc_cyc[0] + 2 : -1);
    end
    if (pop_cyc.size() < 6 || pop_cyc[5] != pop_cyc[0] + 5) begin
      bad++;
      $display("FAIL stream_rate got=%0d exp=%0d", pop_cyc.size() > 5 ? pop_cyc[5] : -1,
               pop_cyc.size() > 0 ? pop_cyc[0] + 5 : -1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (8) cycle(1'b0, 16'h0, 1'b0, 1'b1);
    #1;
    total += 3;
    if (acc_addr.size() != 4) begin bad++; $display("FAIL stall_accepts got=%0d exp=4", acc_addr.size()); end
    if (int'(dut.count) != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", dut.count); end
    if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%b exp=0", bus.imem_req_valid); end
    repeat (10) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) check_seen("stall_pop", i, PC_W'(i));
    total++;
    if (acc_addr.size() < 6 || acc_addr[4] !== 16'd4 || acc_addr[5] !== 16'd5) begin
      bad++;
      $display("FAIL stall_resume got=%0d reqs exp=4,5 next", acc_addr.size());
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 10 && mem_q.size() != 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    total++;
    if (mem_q.size() != 3) begin bad++; $display("FAIL stale_setup got=%0d exp=3 outstanding", mem_q.size()); end
    clear_logs();
    cycle(1'b1, 16'h0040, 1'b1, 1'b1);
    #1;
    total++;
    if (int'(dut.count) != 0) begin bad++; $display("FAIL stale_flush got=%0d exp=0", dut.count); end
    repeat (14) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) check_seen("stale_pop", i, 16'h0040 + PC_W'(i));
  endtask

  task automatic test_redirect_collide();
    int exp_sq;
    bit found;
    do_reset();
    lat_lo = 2; lat_hi = 2;
    repeat (4) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_q.size() != 0 && mem_q[0].due <= cyc && mq.size() != 0) begin found = 1'b1; break; end
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
    end
    total++;
    if (!found) begin bad++; $display("FAIL collide_setup got=0 exp=1"); end
    exp_sq = mem_q.size() - 1;
    clear_logs();
    cycle(1'b1, 16'h1234, 1'b1, 1'b1);
    #1;
    total++;
    if (int'(dut.squash_cnt) != exp_sq) begin
      bad++;
      $display("FAIL collide_squash got=%0d exp=%0d", dut.squash_cnt, exp_sq);
    end
    repeat (10) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    check_seen("collide_pop", 0, 16'h1234);
    check_seen("collide_pop", 1, 16'h1235);
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] exp_w [4];
    exp_w = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    do_reset();
    lat_lo = 1; lat_hi = 1;
    cycle(1'b1, 16'hFFFE, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) check_seen("wrap_pop", i, exp_w[i]);
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat_lo = 2; lat_hi = 4;
    repeat (5) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    clear_logs();
    cycle(1'b1, 16'h0100, 1'b1, 1'b1);
    cycle(1'b1, 16'h0200, 1'b1, 1'b1);
    repeat (20) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    check_seen("b2b_pop", 0, 16'h0200);
    check_seen("b2b_pop", 1, 16'h0201);
  endtask

  task automatic test_random();
    do_reset();
    lat_lo = 1; lat_hi = 4;
    repeat (400) cycle($urandom_range(0, 19) == 0, PC_W'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    #1;
    total++;
    if (int'(dut.count) != mq.size()) begin
      bad++;
      $display("FAIL random_count got=%0d exp=%0d", dut.count, mq.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (6) cycle(1'b0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_req_valid got=%b exp=0", bus.imem_req_valid); end
    if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL mid_dec_valid got=%b exp=0", bus.dec_valid); end
    if (bus.dec_pc !== '0) begin bad++; $display("FAIL mid_dec_pc got=%h exp=0", bus.dec_pc); end
    if (bus.dec_instr !== '0) begin bad++; $display("FAIL mid_dec_instr got=%h exp=0", bus.dec_instr); end
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) cycle(1'b0, 16'h0, 1'b1, 1'b1);
    total++;
    if (acc_addr.size() == 0 || acc_addr[0] !== RESET_PC) begin
      bad++;
      $display("FAIL mid_restart_req got=%0d reqs exp first=%h", acc_addr.size(), RESET_PC);
    end
    check_seen("mid_restart_pop", 0, RESET_PC);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    lat_lo = 1;
    lat_hi = 1;
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_collide();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
